// File: rtl/my_pkg.sv
// Shared pipeline types: ALU opcodes and the divider FSM state.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
//
// ALUOp is the decoder's operation encoding; div_unit only reacts to the
// four RV32M divide/remainder opcodes and ignores every other value.
package my_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_LUI  = 4'd10,
        OP_DIV  = 4'd11,
        OP_DIVU = 4'd12,
        OP_REM  = 4'd13,
        OP_REMU = 4'd14
    } ALUOp;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input ALUOp op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_div_op(input ALUOp op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Latency: done XLEN+1 cycles after start (1 cycle for div-by-zero/overflow with DIV_SPECIAL_FASTPATH_EN).
// Backpressure: none; busy stalls upstream, start is only sampled in IDLE, flush aborts.
//
// Ports:
//   clk, reset     - pipeline clock, synchronous active-high reset
//   start, op      - request a divide; ignored unless op is a divide opcode and the unit is IDLE
//   flush          - aborts any operation in progress; a start in the same cycle is dropped
//   src_a, src_b   - dividend / divisor (forwarded operands)
//   busy           - high whenever the FSM is not IDLE
//   done, result   - one-cycle completion pulse; result is registered and holds between operations
//
// Build option: DIV_SPECIAL_FASTPATH_EN -- when defined, divide-by-zero and signed
// overflow skip the iterations and complete in the cycle after start.
module div_unit
    import my_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  ALUOp            op,
    input  logic            flush,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return -x;
    endfunction

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? negate(x) : x;
    endfunction

    // Special cases take precedence over the sign fix-up so the result does not
    // depend on what the iterations left in quo/rem (or on whether they ran).
    function automatic logic [XLEN-1:0] fix_result(
        input ALUOp            f_op,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic [XLEN-1:0] a_raw,
        input logic            na,
        input logic            nb,
        input logic            dz,
        input logic            ov
    );
        logic is_rem;
        is_rem = (f_op == OP_REM) || (f_op == OP_REMU);
        if (dz)
            return is_rem ? a_raw : ALL_ONES;
        else if (ov)
            return is_rem ? '0 : MIN_INT;
        else begin
            case (f_op)
                OP_DIV:  return (na != nb) ? negate(q) : q;
                OP_REM:  return na ? negate(r) : r;
                OP_DIVU: return q;
                default: return r;
            endcase
        end
    endfunction

    div_state_t      state;
    ALUOp            op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] abs_b;
    logic            neg_a;
    logic            neg_b;
    logic            dz_q;
    logic            ov_q;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;

    // Decode of the incoming request, used only on the IDLE -> CALC/DONE edge.
    logic in_signed;
    logic in_dz;
    logic in_ov;
    logic in_neg_a;
    logic in_neg_b;

    always_comb begin
        in_signed = is_signed_div_op(op);
        in_dz     = (src_b == '0);
        in_ov     = in_signed && (src_a == MIN_INT) && (src_b == ALL_ONES);
        in_neg_a  = in_signed && src_a[XLEN-1];
        in_neg_b  = in_signed && src_b[XLEN-1];
    end

    // One restoring step: shift {rem,quo} left, then try to subtract |b|.
    // The trial is XLEN+1 bits wide so its MSB is a clean borrow flag.
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    always_comb begin
        rem_sh = {rem, quo[XLEN-1]};
        trial  = rem_sh - {1'b0, abs_b};
        if (!trial[XLEN]) begin
            rem_nxt = trial[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[XLEN-1:0];
            quo_nxt = {quo[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= OP_ADD;
            a_q    <= '0;
            abs_b  <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            dz_q   <= 1'b0;
            ov_q   <= 1'b0;
            count  <= '0;
            rem    <= '0;
            quo    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && is_div_op(op)) begin
                        op_q  <= op;
                        a_q   <= src_a;
                        abs_b <= in_signed ? abs_val(src_b) : src_b;
                        neg_a <= in_neg_a;
                        neg_b <= in_neg_b;
                        dz_q  <= in_dz;
                        ov_q  <= in_ov;
                        count <= '0;
                        rem   <= '0;
                        quo   <= in_signed ? abs_val(src_a) : src_a;
`ifdef DIV_SPECIAL_FASTPATH_EN
                        if (in_dz || in_ov) begin
                            state  <= DONE;
                            result <= fix_result(op, '0, '0, src_a, in_neg_a, in_neg_b,
                                                 in_dz, in_ov);
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state  <= DONE;
                        result <= fix_result(op_q, quo_nxt, rem_nxt, a_q, neg_a, neg_b,
                                             dz_q, ov_q);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, scoreboard + done monitor.
// Latency: expected done cycle is recorded per request and compared on completion.
// Backpressure: requests are issued one at a time, the next only after done.
module tb_div_unit;
    import my_pkg::*;

`ifdef DIV_SPECIAL_FASTPATH_EN
    localparam int LAT_SP = 1;
`else
    localparam int LAT_SP = 33;
`endif
    localparam int LAT = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    ALUOp        op;
    logic        flush;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .flush  (flush),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: cycle %0d result %h, required no done", cyc, result);
            end else begin
                e = sb.pop_front();
                if (result !== e.res || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL %s: result %h at cycle %0d, required %h at cycle %0d",
                             e.name, result, cyc, e.res, e.cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; the start cycle is the current cycle.
    task automatic issue(input ALUOp o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit push, input string nm);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (push) sb.push_back('{exp, cyc + lat, nm});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: no done by timeout, required %h at cycle %0d", e.name, e.res, e.cyc);
        end
    endtask

    task automatic run(input ALUOp o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string nm);
        issue(o, a, b, exp, lat, 1'b1, nm);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = OP_ADD;
        src_a = '0;
        src_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("reset_busy",   32'(busy), 32'd0);
        check("reset_done",   32'(done), 32'd0);
        check("reset_result", result,    32'd0);

        // DIVU 100/7 with busy profile over the whole operation.
        check("busy_in_start_cycle", 32'(busy), 32'd0);
        issue(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT, 1'b1, "divu_100_7");
        bad = 0;
        for (int k = 1; k <= 33; k++) begin
            if (busy !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        check("busy_cycles_1_33", 32'(bad), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);

        // Back-to-back: each run starts in the cycle right after the previous done.
        run(OP_REMU, 32'd100,       32'd7,          32'd2,          LAT,    "remu_100_7");
        run(OP_DIV,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD,  LAT,    "div_m7_2");
        run(OP_REM,  32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF,  LAT,    "rem_m7_2");
        run(OP_REM,  32'd7,         32'hFFFF_FFFE,  32'd1,          LAT,    "rem_7_m2");
        run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  LAT_SP, "div_ovf");
        run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          LAT_SP, "rem_ovf");
        run(OP_DIV,  32'd5,         32'd0,          32'hFFFF_FFFF,  LAT_SP, "div_5_0");
        run(OP_REMU, 32'd5,         32'd0,          32'd5,          LAT_SP, "remu_5_0");
        run(OP_REM,  32'hFFFF_FFF8, 32'd0,          32'hFFFF_FFF8,  LAT_SP, "rem_m8_0");
        run(OP_DIVU, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF,  LAT,    "divu_max_1");
        run(OP_DIVU, 32'd7,         32'd9,          32'd0,          LAT,    "divu_7_9");
        run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          LAT,    "divu_no_ovf");

        // Flush at cycle 10 of DIVU 1000/3; restart DIVU 9/3 at cycle 11 -> done at 44.
        issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0, "flushed");
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("busy_after_flush", 32'(busy), 32'd0);
        issue(OP_DIVU, 32'd9, 32'd3, 32'd3, LAT - 1 + 1, 1'b1, "divu_9_3_after_flush");
        wait_idle();

        // start together with flush is dropped.
        flush = 1'b1;
        issue(OP_DIVU, 32'd8, 32'd2, 32'd0, 0, 1'b0, "start_with_flush");
        flush = 1'b0;
        check("busy_start_with_flush", 32'(busy), 32'd0);

        // Reset at cycle 20 of an operation clears busy/done/result.
        issue(OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0, "reset_abort");
        repeat (19) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midop_reset_busy",   32'(busy), 32'd0);
        check("midop_reset_done",   32'(done), 32'd0);
        check("midop_reset_result", result,    32'd0);

        // Non-divide opcode is ignored.
        issue(OP_ADD, 32'd10, 32'd2, 32'd0, 0, 1'b0, "op_add");
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        check("op_add_ignored", 32'(bad), 32'd0);

        run(OP_DIVU, 32'd1000, 32'd3, 32'd333, LAT, "divu_1000_3");
        repeat (3) begin @(posedge clk); #1; end
        check("result_holds", result, 32'd333);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
